truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/cello_tt_pkg.sv | 8 +
 rtl/tt_settle_timer.sv | 17 +
 rtl/truth_table_sweeper.sv | 74 +++++++
 tb/tb_truth_table_sweeper.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cello_tt_pkg.sv
// cello_tt_pkg: shared FSM states, table width and index-to-bit mapping for the truth table sweeper
package cello_tt_pkg;
  localparam int TT_W = 8;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} tt_state_t;
  function automatic logic [2:0] bit_pos(input logic [2:0] idx);
    return ~idx;
  endfunction
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: settle countdown; load sets SETTLE_CYCLES-1, enable counts down, expired at 0 (ports clk, rst, load, enable, expired)
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);
  logic [7:0] cnt;
  assign expired = cnt == 8'd0;
  always_ff @(posedge clk)
    if (rst) cnt <= 8'd0;
    else if (load) cnt <= 8'(SETTLE_CYCLES - 1);
    else if (enable && !expired) cnt <= cnt - 8'd1;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 8 input combinations of a 3-input gate and records its truth table (ports clk, rst, start, abort, dut_out, in1..in3, busy, done, table_out, match)
module truth_table_sweeper
  import cello_tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter logic [TT_W-1:0] EXPECTED = 8'h4E
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_out,
  output logic            in1,
  output logic            in2,
  output logic            in3,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] table_out,
  output logic            match
);
  tt_state_t state_q, state_d;
  logic [2:0] idx_q;
  logic [TT_W-1:0] work_q;
  logic load, enable, expired, go;
  tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .load(load), .enable(enable), .expired(expired)
  );
  assign go = (state_q == IDLE) && start && !abort;
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    enable = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = go ? SETTLE : IDLE;
        load = go;
      end
      SETTLE: begin
        state_d = abort ? IDLE : expired ? SAMPLE : SETTLE;
        enable = 1'b1;
      end
      SAMPLE: begin
        state_d = abort ? IDLE : (idx_q == 3'd7) ? DONE : SETTLE;
        load = !abort && idx_q != 3'd7;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= 3'd0;
      work_q <= '0;
      table_out <= '0;
      match <= 1'b0;
    end else begin
      state_q <= state_d;
      if (go) begin
        idx_q <= 3'd0;
        work_q <= '0;
      end
      if (state_q == SAMPLE && !abort) begin
        work_q[bit_pos(idx_q)] <= dut_out;
        if (idx_q != 3'd7) idx_q <= idx_q + 3'd1;
      end
      if (state_q == DONE) begin
        table_out <= work_q;
        match <= work_q == EXPECTED;
      end
    end
  assign busy = state_q == SETTLE || state_q == SAMPLE;
  assign done = state_q == DONE;
  assign {in1, in2, in3} = busy ? idx_q : 3'd0;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of the sweeper with SETTLE_CYCLES=4 (dut a) and SETTLE_CYCLES=1 (dut b)
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, zero_a = 1'b0, start_b = 1'b0;
  logic a_in1, a_in2, a_in3, a_busy, a_done, a_match, a_out;
  logic b_in1, b_in2, b_in3, b_busy, b_done, b_match, b_out;
  logic [7:0] a_table, b_table;
  logic [7:0] gate = 8'h4E;
  int n_checks = 0;
  int n_fail = 0;
  int dcyc, pulses, hmin, hmax;

  always #5 clk = ~clk;

  assign a_out = zero_a ? 1'b0 : gate[~{a_in1, a_in2, a_in3}];
  assign b_out = gate[~{b_in1, b_in2, b_in3}];

  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'h4E)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .dut_out(a_out),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .busy(a_busy), .done(a_done),
    .table_out(a_table), .match(a_match)
  );
  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'h4E)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .dut_out(b_out),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .busy(b_busy), .done(b_done),
    .table_out(b_table), .match(b_match)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ins(input bit sel);
    return sel ? {b_in1, b_in2, b_in3} : {a_in1, a_in2, a_in3};
  endfunction

  // Start a sweep, then watch 60 edges: first done cycle (counted from the acceptance edge), done pulses, per-combination hold lengths.
  task automatic run_sweep(input bit sel, input bit restart, output int dc, output int np, output int mn, output int mx);
    int hist [8];
    foreach (hist[i]) hist[i] = 0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    dc = -1; np = 0; mn = 1000; mx = 0;
    if (sel ? b_busy : a_busy) hist[ins(sel)]++;
    for (int n = 1; n <= 60; n++) begin
      if (restart) start_a = (n >= 5 && n <= 20);
      @(posedge clk); #1;
      if (sel ? b_done : a_done) begin
        np++;
        if (dc < 0) dc = n + 1;
      end
      if (sel ? b_busy : a_busy) hist[ins(sel)]++;
    end
    start_a = 1'b0;
    foreach (hist[i]) begin
      if (hist[i] < mn) mn = hist[i];
      if (hist[i] > mx) mx = hist[i];
    end
  endtask

  task automatic wait_ins(input logic [2:0] v);
    int k = 0;
    while (!(a_busy && {a_in1, a_in2, a_in3} == v) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_idx", 32'({a_in1, a_in2, a_in3}), 32'(v));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_ins", 32'({a_in1, a_in2, a_in3}), 0);
    check("rst_table", 32'(a_table), 0);
    check("rst_match", 32'(a_match), 0);
    check("rst_b_table", 32'(b_table), 0);

    run_sweep(0, 0, dcyc, pulses, hmin, hmax);
    check("nom_done_cycle", dcyc, 41);
    check("nom_pulses", pulses, 1);
    check("nom_hold_min", hmin, 5);
    check("nom_hold_max", hmax, 5);
    check("nom_table", 32'(a_table), 32'h4E);
    check("nom_match", 32'(a_match), 1);

    zero_a = 1'b1;
    run_sweep(0, 0, dcyc, pulses, hmin, hmax);
    check("zero_done_cycle", dcyc, 41);
    check("zero_table", 32'(a_table), 0);
    check("zero_match", 32'(a_match), 0);
    zero_a = 1'b0;

    run_sweep(0, 1, dcyc, pulses, hmin, hmax);
    check("restart_pulses", pulses, 1);
    check("restart_done_cycle", dcyc, 41);
    check("restart_table", 32'(a_table), 32'h4E);
    check("restart_match", 32'(a_match), 1);

    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_ins(3'd3);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    check("abort_busy", 32'(a_busy), 0);
    check("abort_ins", 32'({a_in1, a_in2, a_in3}), 0);
    check("abort_done", 32'(a_done), 0);
    pulses = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (a_done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_table", 32'(a_table), 32'h4E);
    check("abort_match", 32'(a_match), 1);

    start_a = 1'b1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    abort_a = 1'b0;
    check("abort_start_busy", 32'(a_busy), 0);

    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_ins(3'd5);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(a_busy), 0);
    check("midrst_done", 32'(a_done), 0);
    check("midrst_ins", 32'({a_in1, a_in2, a_in3}), 0);
    check("midrst_table", 32'(a_table), 0);
    check("midrst_match", 32'(a_match), 0);
    run_sweep(0, 0, dcyc, pulses, hmin, hmax);
    check("postrst_done_cycle", dcyc, 41);
    check("postrst_table", 32'(a_table), 32'h4E);
    check("postrst_match", 32'(a_match), 1);

    run_sweep(1, 0, dcyc, pulses, hmin, hmax);
    check("s1_done_cycle", dcyc, 17);
    check("s1_pulses", pulses, 1);
    check("s1_hold_min", hmin, 2);
    check("s1_hold_max", hmax, 2);
    check("s1_table", 32'(b_table), 32'h4E);
    check("s1_match", 32'(b_match), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
